// File: rtl/shared_bus_interconnect.sv
// Shared-memory interconnect: NUM_CORES cores onto one global memory port and one device window.
// Round-robin arbitration with an atomic lock by default; STATIC_ARBITRATION_EN selects a rotating time-slot grant.
module shared_bus_interconnect #(
    parameter int NUM_CORES     = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int DEV_ADDR_BITS = 10,
    parameter int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             core_request,
    input  logic [NUM_CORES-1:0]             core_lock,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
    input  logic [NUM_CORES-1:0]             core_wren,
    input  logic [NUM_CORES-1:0]             core_rden,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_write_val,
    output logic [NUM_CORES-1:0]             core_ready,
    output logic [NUM_CORES-1:0]             core_read_valid,
    output logic [DATA_WIDTH-1:0]            core_read_val,
    output logic [ADDR_WIDTH-1:0]            gmem_addr,
    output logic                             gmem_we,
    output logic [DATA_WIDTH-1:0]            gmem_data_out,
    input  logic [DATA_WIDTH-1:0]            gmem_q,
    output logic [CORE_ID_WIDTH-1:0]         device_core_id,
    output logic                             device_write_en,
    output logic                             device_read_en,
    output logic [DEV_ADDR_BITS-1:0]         device_addr,
    output logic [DATA_WIDTH-1:0]            device_data_out,
    input  logic [DATA_WIDTH-1:0]            device_data_in
);

    logic [CORE_ID_WIDTH-1:0] gnt_idx;
    logic [CORE_ID_WIDTH-1:0] last_idx;
    logic [CORE_ID_WIDTH-1:0] sel_idx;
    logic                     gnt_any;
    logic [NUM_CORES-1:0]     gnt_oh;
    logic [NUM_CORES-1:0]     acc_oh;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic                     dev_sel;
    logic                     sel_wren;
    logic                     sel_rden;
    logic [NUM_CORES-1:0]     rd_oh;
    logic                     dev_sel_l;

`ifdef STATIC_ARBITRATION_EN
    logic [NUM_CORES-1:0] slot;

    always_ff @(posedge clk) begin
        if (reset) slot <= NUM_CORES'(1);
        else       slot <= {slot[NUM_CORES-2:0], slot[NUM_CORES-1]};
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (slot[i]) gnt_idx = CORE_ID_WIDTH'(i);
        end
    end

    // The slot is owned whether or not the core uses it; only a requesting owner drives the buses.
    assign gnt_oh     = slot;
    assign gnt_any    = core_request[gnt_idx];
    assign core_ready = slot;
`else
    logic [CORE_ID_WIDTH-1:0] prio;
    logic                     locked;
    logic [CORE_ID_WIDTH-1:0] lock_owner;
    logic                     forced;
    int                       idx;

    assign forced = locked && core_request[lock_owner];

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = prio;
        idx     = 0;
        if (forced) begin
            gnt_any = 1'b1;
            gnt_idx = lock_owner;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                idx = (int'(prio) + i) % NUM_CORES;
                if (!gnt_any && core_request[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CORE_ID_WIDTH'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    end

    assign core_ready = gnt_oh;

    // A lock-forced grant leaves the pointer where the locking access left it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio       <= '0;
            locked     <= 1'b0;
            lock_owner <= '0;
        end else begin
            locked <= gnt_any & core_lock[gnt_idx];
            if (gnt_any) lock_owner <= gnt_idx;
            if (gnt_any && !forced)
                prio <= (gnt_idx == CORE_ID_WIDTH'(NUM_CORES-1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)        last_idx <= '0;
        else if (gnt_any) last_idx <= gnt_idx;
    end

    // With no grant the buses keep showing the last granted core.
    assign sel_idx  = gnt_any ? gnt_idx : last_idx;
    assign sel_addr = core_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign dev_sel  = &sel_addr[ADDR_WIDTH-1:DEV_ADDR_BITS];
    assign sel_wren = core_wren[sel_idx];
    assign sel_rden = core_rden[sel_idx];
    assign acc_oh   = gnt_any ? gnt_oh : '0;

    assign gmem_addr       = sel_addr;
    assign gmem_data_out   = core_write_val[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign gmem_we         = gnt_any & sel_wren & ~dev_sel;
    assign device_core_id  = sel_idx;
    assign device_write_en = gnt_any & sel_wren & dev_sel;
    assign device_read_en  = gnt_any & sel_rden & dev_sel;
    assign device_addr     = sel_addr[DEV_ADDR_BITS-1:0];
    assign device_data_out = gmem_data_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_oh     <= '0;
            dev_sel_l <= 1'b0;
        end else begin
            rd_oh     <= acc_oh & core_rden;
            dev_sel_l <= dev_sel;
        end
    end

    // Reset gates the valid immediately so a read in flight is dropped.
    assign core_read_valid = reset ? '0 : rd_oh;
    assign core_read_val   = dev_sel_l ? device_data_in : gmem_q;

endmodule
